fft_result_capture: RTL and testbench

- Upstream neighbour of the memory comparator.
- Accepts a stream of 32 FFT output words over a valid/ready handshake and writes them into the result memory (memory B), optionally in bit-reversed address order.
- When all 32 words have been written, raises start_comp so the comparator can check memory B against the golden memory A.
- Each capture is armed by a rising edge on arm.

---
 rtl/fft_result_capture.sv | 99 +++++++++
 tb/tb_fft_result_capture.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_capture.sv
// Captures one 32-word FFT frame from a valid/ready stream into the result memory,
// optionally bit-reversing the write address, then triggers the comparator.
module fft_result_capture #(
   parameter int DATA_W      = 64,
   parameter int ADDR_W      = 5,
   parameter bit BIT_REVERSE = 1'b1
) (
   input  logic              clk,
   input  logic              sclr,
   input  logic              arm,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_we,
   output logic              start_comp,
   output logic              busy,
   output logic              capture_done,
   output logic              overflow_err
);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      FLUSH,
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              arm_d;
   logic              arm_pulse;
   logic              accept;
   logic              entering_capture;
   logic [ADDR_W-1:0] count;

   function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] v);
      logic [ADDR_W-1:0] r;
      for (int i = 0; i < ADDR_W; i++) begin
         r[i] = v[ADDR_W-1-i];
      end
      return r;
   endfunction

   assign arm_pulse        = arm & ~arm_d;
   // Gated by sclr so nothing is accepted in the cycle the abort takes effect.
   assign in_ready         = (state == CAPTURE) && !sclr;
   assign accept           = in_valid & in_ready;
   assign entering_capture = (state != CAPTURE) && (state_next == CAPTURE);

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (arm_pulse) state_next = CAPTURE;
         CAPTURE: if (accept && (count == {ADDR_W{1'b1}})) state_next = FLUSH;
         FLUSH:   state_next = DONE;
         DONE:    if (arm_pulse) state_next = CAPTURE;
         default: state_next = IDLE;
      endcase
   end

   // Status flags are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk) begin
      if (sclr) begin
         state        <= IDLE;
         arm_d        <= 1'b0;
         count        <= '0;
         mem_we       <= 1'b0;
         mem_address  <= '0;
         mem_data     <= '0;
         start_comp   <= 1'b0;
         busy         <= 1'b0;
         capture_done <= 1'b0;
         overflow_err <= 1'b0;
      end else begin
         state  <= state_next;
         arm_d  <= arm;
         mem_we <= accept;
         if (accept) begin
            mem_data    <= in_data;
            mem_address <= BIT_REVERSE ? bitrev(count) : count;
            count       <= count + 1'b1;
         end
         if (entering_capture) begin
            count <= '0;
         end
         if (entering_capture) begin
            overflow_err <= 1'b0;
         end else if (in_valid && (state != CAPTURE)) begin
            overflow_err <= 1'b1;
         end
         busy         <= (state_next == CAPTURE) || (state_next == FLUSH);
         capture_done <= (state_next == DONE);
         start_comp   <= (state_next == DONE);
      end
   end

endmodule

// File: tb/tb_fft_result_capture.sv
// Directed bench for fft_result_capture: a bit-reversed and a natural-order instance
// share one stimulus stream and are checked every cycle against a frame-level model.
module tb_fft_result_capture;

   localparam int DW = 64;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          sclr;
   logic          arm;
   logic          in_valid;
   logic [DW-1:0] in_data;

   logic          r_ready, r_we, r_start, r_busy, r_done, r_ovf;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;
   logic          n_ready, n_we, n_start, n_busy, n_done, n_ovf;
   logic [AW-1:0] n_addr;
   logic [DW-1:0] n_data;

   always #5 clk = ~clk;

   fft_result_capture #(.DATA_W(DW), .ADDR_W(AW), .BIT_REVERSE(1'b1)) dut_rev (
      .clk(clk), .sclr(sclr), .arm(arm), .in_valid(in_valid), .in_data(in_data),
      .in_ready(r_ready), .mem_address(r_addr), .mem_data(r_data), .mem_we(r_we),
      .start_comp(r_start), .busy(r_busy), .capture_done(r_done), .overflow_err(r_ovf)
   );

   fft_result_capture #(.DATA_W(DW), .ADDR_W(AW), .BIT_REVERSE(1'b0)) dut_nat (
      .clk(clk), .sclr(sclr), .arm(arm), .in_valid(in_valid), .in_data(in_data),
      .in_ready(n_ready), .mem_address(n_addr), .mem_data(n_data), .mem_we(n_we),
      .start_comp(n_start), .busy(n_busy), .capture_done(n_done), .overflow_err(n_ovf)
   );

   int errors = 0;
   int checks = 0;
   bit checking = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit s, input bit a, input bit v, input logic [DW-1:0] d);
      @(posedge clk);
      #1;
      sclr     = s;
      arm      = a;
      in_valid = v;
      in_data  = d;
   endtask

   function automatic logic [4:0] rev5(input int v);
      logic [4:0] r;
      for (int i = 0; i < 5; i++) r[i] = v[4-i];
      return r;
   endfunction

   // Frame-level model: a frame is open for exactly 32 accepted samples, then one
   // flush cycle, then done until the next arm rising edge.
   bit            cap = 0, flush = 0, done = 0, prev_arm = 0, pulse, acc, starting;
   int            n = 0;
   logic          e_we = 0, e_busy = 0, e_done = 0, e_start = 0, e_ovf = 0, e_zero = 0;
   logic [AW-1:0] e_addr_r = '0, e_addr_n = '0;
   logic [DW-1:0] e_data = '0;

   logic [AW-1:0] log_r [512];
   logic [AW-1:0] log_n [512];
   logic [DW-1:0] log_d [512];
   int            wcnt_r = 0, wcnt_n = 0, cyc = 0, acc_cyc = 0, start_cyc = 0;
   logic          prev_start = 0;

   always @(negedge clk) begin
      cyc++;
      if (checking) begin
         checkOutput("in_ready_rev", r_ready, cap && !sclr);
         checkOutput("in_ready_nat", n_ready, cap && !sclr);
         checkOutput("mem_we_rev", r_we, e_we);
         checkOutput("mem_we_nat", n_we, e_we);
         if (e_we || e_zero) begin
            checkOutput("mem_address_rev", r_addr, e_addr_r);
            checkOutput("mem_address_nat", n_addr, e_addr_n);
            checkOutput("mem_data_rev", r_data, e_data);
            checkOutput("mem_data_nat", n_data, e_data);
         end
         checkOutput("busy_rev", r_busy, e_busy);
         checkOutput("busy_nat", n_busy, e_busy);
         checkOutput("capture_done_rev", r_done, e_done);
         checkOutput("capture_done_nat", n_done, e_done);
         checkOutput("start_comp_rev", r_start, e_start);
         checkOutput("start_comp_nat", n_start, e_start);
         checkOutput("overflow_err_rev", r_ovf, e_ovf);
         checkOutput("overflow_err_nat", n_ovf, e_ovf);
      end
      if (r_we === 1'b1 && wcnt_r < 512) begin
         log_r[wcnt_r] = r_addr;
         log_d[wcnt_r] = r_data;
         wcnt_r++;
      end
      if (n_we === 1'b1 && wcnt_n < 512) begin
         log_n[wcnt_n] = n_addr;
         wcnt_n++;
      end
      if (in_valid && r_ready === 1'b1) acc_cyc = cyc;
      if (r_start === 1'b1 && prev_start !== 1'b1) start_cyc = cyc;
      prev_start = r_start;

      if (sclr) begin
         cap = 0; flush = 0; done = 0; n = 0; prev_arm = 0;
         e_we = 0; e_addr_r = '0; e_addr_n = '0; e_data = '0;
         e_busy = 0; e_done = 0; e_start = 0; e_ovf = 0; e_zero = 1;
      end else begin
         pulse    = arm && !prev_arm;
         prev_arm = arm;
         acc      = cap && in_valid;
         starting = pulse && !cap && !flush;
         e_zero   = 0;
         e_we     = acc;
         if (acc) begin
            e_data   = in_data;
            e_addr_n = 5'(n);
            e_addr_r = rev5(n);
            n++;
         end
         if (starting) e_ovf = 0;
         else if (in_valid && !cap) e_ovf = 1;
         if (acc && n == 32) begin
            cap = 0; flush = 1;
         end else if (flush) begin
            flush = 0; done = 1;
         end else if (starting) begin
            cap = 1; n = 0; done = 0;
         end
         e_busy  = cap || flush;
         e_done  = done;
         e_start = done;
      end
   end

   int br, bn;

   initial begin
      sclr = 1'b1; arm = 1'b0; in_valid = 1'b0; in_data = '0;
      applyStimulus(1, 0, 0, 0);
      checking = 1'b1;
      applyStimulus(0, 0, 0, 0);
      checkOutput("reset_busy", r_busy, 1'b0);
      checkOutput("reset_start_comp", r_start, 1'b0);

      // Basic bit-reversed frame, data = index
      br = wcnt_r; bn = wcnt_n;
      applyStimulus(0, 1, 0, 0);
      for (int k = 0; k < 32; k++) applyStimulus(0, 1, 1, DW'(k));
      for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 0);
      checkOutput("basic_write_count", wcnt_r - br, 32);
      checkOutput("basic_addr_k1", log_r[br+1], 16);
      checkOutput("basic_addr_k3", log_r[br+3], 24);
      checkOutput("basic_data_k5", log_d[br+5], 5);
      checkOutput("basic_nat_addr_k1", log_n[bn+1], 1);
      checkOutput("basic_start_latency", start_cyc - acc_cyc, 2);
      checkOutput("basic_done", r_done, 1'b1);
      checkOutput("basic_busy", r_busy, 1'b0);

      // Natural order with every other cycle idle
      br = wcnt_r; bn = wcnt_n;
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
      for (int k = 0; k < 64; k++) applyStimulus(0, 1, (k % 2) == 0, DW'(100 + k / 2));
      for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 0);
      checkOutput("gaps_write_count", wcnt_n - bn, 32);
      for (int i = 0; i < 32; i++) begin
         checkOutput("gaps_nat_addr", log_n[bn+i], i);
         checkOutput("gaps_data", log_d[br+i], 100 + i);
      end
      checkOutput("gaps_start_comp", r_start, 1'b1);

      // Extra samples past the frame end
      br = wcnt_r;
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
      for (int k = 0; k < 40; k++) applyStimulus(0, 1, 1, DW'(200 + k));
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("extra_write_count", wcnt_r - br, 32);
      checkOutput("extra_overflow", r_ovf, 1'b1);
      checkOutput("extra_in_ready", r_ready, 1'b0);

      // Held arm must not restart; a fresh edge does
      for (int k = 0; k < 5; k++) applyStimulus(0, 1, 0, 0);
      checkOutput("held_arm_done", r_done, 1'b1);
      checkOutput("held_arm_busy", r_busy, 1'b0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("rearm_start_comp", r_start, 1'b0);
      checkOutput("rearm_overflow", r_ovf, 1'b0);
      checkOutput("rearm_busy", r_busy, 1'b1);

      // Reset after 10 accepts, arm left high through reset
      br = wcnt_r;
      for (int k = 0; k < 10; k++) applyStimulus(0, 1, 1, DW'(300 + k));
      applyStimulus(1, 1, 0, 0);
      applyStimulus(0, 1, 0, 0);
      checkOutput("abort_mem_we", r_we, 1'b0);
      checkOutput("abort_addr", r_addr, 0);
      checkOutput("abort_data", r_data, 0);
      checkOutput("abort_busy", r_busy, 1'b0);
      checkOutput("abort_in_ready", r_ready, 1'b0);
      checkOutput("abort_write_count", wcnt_r - br, 10);

      // Frame after reset, with an arm edge mid-frame that must be ignored
      br = wcnt_r; bn = wcnt_n;
      for (int k = 0; k < 32; k++) applyStimulus(0, (k != 14), 1, DW'(400 + k));
      for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, 0);
      checkOutput("midarm_write_count", wcnt_n - bn, 32);
      checkOutput("midarm_first_addr", log_n[bn], 0);
      checkOutput("midarm_last_addr", log_n[bn+31], 31);
      checkOutput("midarm_last_data", log_d[br+31], 431);
      checkOutput("midarm_start_comp", r_start, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
